acc4_seq: RTL and testbench
===========================

ACC4_SEQ -- requirements
Module: acc4_seq

Interface
REQ-001 Parameter NUM_OPS, default 4, number of 4-bit operands summed per burst; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a burst; honoured only in IDLE.
REQ-005 in_valid  input  1  in_data holds a valid operand this cycle.
REQ-006 in_data  input  4  unsigned operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 sum  output  4  registered running/final sum, modulo 16.
REQ-009 ovf  output  1  sticky flag, set when any addition in the burst carried out of bit 3.
REQ-010 busy  output  1  high in ACC and DONE states.
REQ-011 done  output  1  one-cycle pulse marking final sum valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACC, DONE.
REQ-013 IDLE: in_ready=0, busy=0, done=0; start=1 -> sum<=0, ovf<=0, count<=0, next state ACC.
REQ-014 ACC: in_ready=1, busy=1; an operand is accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 On acceptance: sum<=(sum+in_data) mod 16; ovf<=ovf OR carry-out of that 4-bit add; count<=count+1.
REQ-016 in_valid=0 in ACC: sum, ovf, count hold; no timeout.
REQ-017 Acceptance with count==NUM_OPS-1 SHALL move the FSM to DONE on the same edge; updated sum/ovf visible in DONE cycle.
REQ-018 DONE: done=1, in_ready=0, busy=1 for exactly one cycle, then unconditionally IDLE.
REQ-019 sum and ovf SHALL hold their final values in IDLE until the next accepted start.
REQ-020 start asserted in ACC or DONE SHALL be ignored (no restart, no state change).
REQ-021 start and in_valid both high in IDLE: start honoured, operand not accepted (in_ready=0).
REQ-022 NUM_OPS=1: first accepted operand goes ACC->DONE directly.
REQ-023 Latency: done pulses the cycle after the NUM_OPS-th acceptance edge; minimum burst length start-to-done = NUM_OPS+1 cycles.
REQ-024 count SHALL be 4 bits; it never wraps because the burst terminates at NUM_OPS.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sum=0, ovf=0, count=0, done=0, in_ready=0, busy=0, independent of clk.
REQ-026 Reset mid-burst SHALL discard the partial sum; after release the block waits for a new start.
REQ-027 First start is honoured on the first rising clk edge after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, ACC, DONE) and the operand width constant (4).
REQ-029 The 4-bit add SHALL be performed by one instance of the existing combinational adder4 sub-module, extended to expose carry-out; no other sub-modules.
REQ-030 All outputs SHALL be registered or decoded only from the state register; no combinational path from inputs to outputs.

Verification
REQ-031 NUM_OPS=4, start, operands 1,2,3,4 back-to-back -> done pulse 5 cycles after start, sum=10, ovf=0.
REQ-032 NUM_OPS=4, operands 8,8,1,0 -> sum=1, ovf=1 (carry on 8+8), ovf remains 1 through final add.
REQ-033 NUM_OPS=4, operands 1,2,3,4 with in_valid low 2 cycles between each -> sum=10, done 11 cycles after start, no extra acceptances.
REQ-034 Assert rst_n=0 after 2 accepted operands (3,5), then start with 1,1,1,1 -> sum=4, ovf=0; outputs zero during reset.
REQ-035 Pulse start while in ACC after 1 operand -> ignored; burst completes with expected sum; start with in_valid high in IDLE -> operand not counted.
REQ-036 NUM_OPS=1, operand 15 -> done next cycle, sum=15, ovf=0; sum=15 held in IDLE for 10 cycles.

Source files
------------

// File: rtl/acc4_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : acc4_seq_pkg
// Purpose  : Shared state encoding and operand width for the 4-bit
//            burst accumulator.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package acc4_seq_pkg;

  // Width of each operand and of the running sum.
  localparam int c_OP_W  = 4;
  // Width of the accepted-operand counter.
  localparam int c_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : acc4_seq_pkg
`default_nettype wire

// File: rtl/acc4_seq_adder4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : adder4
// Purpose  : Combinational 4-bit unsigned adder with carry-out.
// Revision : 1.1 - carry-out exposed
// ---------------------------------------------------------------------------
module adder4
  import acc4_seq_pkg::*;
(
  input  logic [c_OP_W-1:0] a_i,
  input  logic [c_OP_W-1:0] b_i,
  output logic [c_OP_W-1:0] sum_o,
  output logic              co_o
);

  // Zero-extend both operands so the top bit of the result is the carry.
  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule : adder4
`default_nettype wire

// File: rtl/acc4_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : acc4_seq
// Purpose  : Sums a burst of NUM_OPS 4-bit operands (mod 16) with a sticky
//            carry-out flag; three-state IDLE/ACC/DONE controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module acc4_seq
  import acc4_seq_pkg::*;
#(
  parameter int NUM_OPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [c_OP_W-1:0] in_data,
  output logic              in_ready,
  output logic [c_OP_W-1:0] sum,
  output logic              ovf,
  output logic              busy,
  output logic              done
);

  // Count value at which the next acceptance completes the burst.
  localparam logic [c_CNT_W-1:0] LAST_CNT = c_CNT_W'(NUM_OPS - 1);

  state_t               state_q, state_d;
  logic [c_OP_W-1:0]    sum_q,   sum_d;
  logic                 ovf_q,   ovf_d;
  logic [c_CNT_W-1:0]   count_q, count_d;

  logic [c_OP_W-1:0]    add_sum;
  logic                 add_co;

  // Running sum plus the operand currently on the input.
  adder4 u_adder4 (
    .a_i   (sum_q),
    .b_i   (in_data),
    .sum_o (add_sum),
    .co_o  (add_co)
  );

  // State and datapath registers; reset is asynchronous and clears the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; everything holds unless a transition fires.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sum_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        // in_ready is implicitly high here, so in_valid alone qualifies.
        if (in_valid) begin
          sum_d   = add_sum;
          ovf_d   = ovf_q | add_co;
          count_d = count_q + 4'd1;
          if (count_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers or decoded state only.
  assign in_ready = (state_q == ACC);
  assign busy     = (state_q == ACC) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign ovf      = ovf_q;

endmodule : acc4_seq
`default_nettype wire

// File: tb/tb_acc4_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_acc4_seq
// Purpose  : Directed self-checking bench for acc4_seq (NUM_OPS=4 and 1).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_acc4_seq;

  logic       clk;
  logic       rst_n;
  logic       start, in_valid;
  logic [3:0] in_data;
  logic       in_ready, ovf, busy, done;
  logic [3:0] sum;

  logic       start1, in_valid1;
  logic [3:0] in_data1;
  logic       in_ready1, ovf1, busy1, done1;
  logic [3:0] sum1;

  int n_cmp = 0;
  int n_err = 0;

  acc4_seq #(.NUM_OPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .sum(sum), .ovf(ovf),
    .busy(busy), .done(done)
  );

  acc4_seq #(.NUM_OPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1),
    .in_data(in_data1), .in_ready(in_ready1), .sum(sum1), .ovf(ovf1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a burst, feed four operands back to back, return to the DONE cycle.
  task automatic burst4(input logic [3:0] a, b, c, d);
    logic [3:0] ops [4];
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ops[i]; tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 4'd0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 4'd0;
    #3;
    n_cmp++;
    if ({in_ready, busy, done, ovf, sum} !== 8'd0) begin
      n_err++; $display("FAIL reset_outputs got %b exp 00000000", {in_ready, busy, done, ovf, sum});
    end
    tick(); tick();
    rst_n = 1'b1;
    // First start right after release must be taken on the next edge.
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL first_start got busy=%b rdy=%b exp 1 1", busy, in_ready);
    end
    // 2+4+6+15 = 27 -> 11 mod 16 with carry on the last add.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 4'd2 : (i == 1) ? 4'd4 : (i == 2) ? 4'd6 : 4'd15;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || sum !== 4'd11 || ovf !== 1'b1) begin
      n_err++; $display("FAIL first_burst got done=%b sum=%0d ovf=%b exp 1 11 1", done, sum, ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    start = 1'b1; tick(); start = 1'b0; cyc = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i); tick(); cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || cyc != 5) begin
      n_err++; $display("FAIL b2b_done got done=%b at cycle %0d exp 1 at 5", done, cyc);
    end
    n_cmp++;
    if (sum !== 4'd10 || ovf !== 1'b0) begin
      n_err++; $display("FAIL b2b_sum got sum=%0d ovf=%b exp 10 0", sum, ovf);
    end
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_done_flags got busy=%b rdy=%b exp 1 0", busy, in_ready);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 4'd10) begin
      n_err++; $display("FAIL b2b_idle got done=%b busy=%b sum=%0d exp 0 0 10", done, busy, sum);
    end
  endtask

  task automatic test_overflow();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd8; tick();
    in_data = 4'd8; tick();
    n_cmp++;
    if (sum !== 4'd0 || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_mid got sum=%0d ovf=%b exp 0 1", sum, ovf);
    end
    in_data = 4'd1; tick();
    in_data = 4'd0; tick();
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || sum !== 4'd1 || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_final got done=%b sum=%0d ovf=%b exp 1 1 1", done, sum, ovf);
    end
    tick();
  endtask

  task automatic test_gaps();
    int cyc;
    start = 1'b1; tick(); start = 1'b0; cyc = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i); tick(); cyc++;
      in_valid = 1'b0;
      if (i < 4) begin
        tick(); tick(); cyc += 2;
        // Idle cycles in ACC must hold the running sum.
        if (i == 1) begin
          n_cmp++;
          if (sum !== 4'd1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL gap_hold got sum=%0d rdy=%b exp 1 1", sum, in_ready);
          end
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1 || cyc != 11 || sum !== 4'd10) begin
      n_err++; $display("FAIL gap_done got done=%b cyc=%0d sum=%0d exp 1 11 10", done, cyc, sum);
    end
    tick();
  endtask

  task automatic test_reset_midburst();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd3; tick();
    in_data = 4'd5; tick();
    in_valid = 1'b0;
    n_cmp++;
    if (sum !== 4'd8) begin
      n_err++; $display("FAIL mid_partial got sum=%0d exp 8", sum);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, busy, done, ovf, sum} !== 8'd0) begin
      n_err++; $display("FAIL mid_async_rst got %b exp 00000000", {in_ready, busy, done, ovf, sum});
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || sum !== 4'd0) begin
      n_err++; $display("FAIL mid_wait_start got busy=%b sum=%0d exp 0 0", busy, sum);
    end
    burst4(4'd1, 4'd1, 4'd1, 4'd1);
    n_cmp++;
    if (done !== 1'b1 || sum !== 4'd4 || ovf !== 1'b0) begin
      n_err++; $display("FAIL mid_rerun got done=%b sum=%0d ovf=%b exp 1 4 0", done, sum, ovf);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd5; tick();
    in_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || sum !== 4'd5) begin
      n_err++; $display("FAIL acc_start_ign got rdy=%b sum=%0d exp 1 5", in_ready, sum);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'd1; tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || sum !== 4'd8) begin
      n_err++; $display("FAIL acc_start_done got done=%b sum=%0d exp 1 8", done, sum);
    end
    // start during DONE must not re-enter ACC.
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sum !== 4'd8) begin
      n_err++; $display("FAIL done_start_ign got busy=%b sum=%0d exp 0 8", busy, sum);
    end
    // start with a valid operand in IDLE: operand must be dropped.
    start = 1'b1; in_valid = 1'b1; in_data = 4'd7;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_ready got %b exp 0", in_ready);
    end
    tick(); start = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (sum !== 4'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_operand got sum=%0d rdy=%b exp 0 1", sum, in_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i); tick();
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL idle_operand_count got done=%b exp 0 after 3 ops", done);
    end
    in_data = 4'd4; tick(); in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || sum !== 4'd10) begin
      n_err++; $display("FAIL idle_operand_sum got done=%b sum=%0d exp 1 10", done, sum);
    end
    tick();
  endtask

  task automatic test_single();
    int bad;
    start1 = 1'b1; tick(); start1 = 1'b0;
    n_cmp++;
    if (in_ready1 !== 1'b1) begin
      n_err++; $display("FAIL single_acc got rdy=%b exp 1", in_ready1);
    end
    in_valid1 = 1'b1; in_data1 = 4'd15; tick(); in_valid1 = 1'b0;
    n_cmp++;
    if (done1 !== 1'b1 || sum1 !== 4'd15 || ovf1 !== 1'b0) begin
      n_err++; $display("FAIL single_done got done=%b sum=%0d ovf=%b exp 1 15 0", done1, sum1, ovf1);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sum1 !== 4'd15 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL single_hold got %0d bad idle cycles, sum=%0d exp 0 bad, 15", bad, sum1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overflow();
    test_gaps();
    test_reset_midburst();
    test_start_ignored();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_acc4_seq
`default_nettype wire
